mem_bus_arbiter: RTL and testbench

MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

---
 rtl/mem_bus_arbiter.sv | 119 +++++++++++
 tb/tb_mem_bus_arbiter.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_arbiter.sv
// Two-master round-robin arbiter onto a shared RAM/IO slave bus: IDLE -> ACCESS -> RESP.
// Latency: grant at edge N, strobes in cycle N+1, done/err pulse in cycle N+2; masters hold req until done.
module mem_bus_arbiter #(
    parameter logic [31:0] RAM_LIMIT = 32'h0000_1000,
    parameter logic [31:0] IO_BASE   = 32'h0000_1000,
    parameter logic [31:0] IO_LAST   = 32'h0000_100F
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        m0_req,
    input  logic        m1_req,
    input  logic        m0_we,
    input  logic        m1_we,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m0_wdata,
    input  logic [31:0] m1_wdata,
    input  logic [2:0]  m0_funct3,
    input  logic [2:0]  m1_funct3,
    output logic        m0_done,
    output logic        m1_done,
    output logic        m0_err,
    output logic        m1_err,
    output logic [31:0] rdata,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [2:0]  bus_funct3,
    output logic        ram_we,
    output logic        io_we,
    input  logic [31:0] ram_rdata,
    input  logic [31:0] io_rdata
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t      state;
    logic        last_owner;
    logic        owner;
    logic        we_q;

    logic        grant_m1;
    logic        g_we;
    logic [31:0] g_addr;
    logic [31:0] g_wdata;
    logic [2:0]  g_funct3;
    logic        g_ram;
    logic        g_io;
    logic        q_ram;
    logic        q_io;

    // On a tie the master that did not own the bus last time wins.
    assign grant_m1 = m1_req && (!m0_req || !last_owner);
    assign g_we     = grant_m1 ? m1_we     : m0_we;
    assign g_addr   = grant_m1 ? m1_addr   : m0_addr;
    assign g_wdata  = grant_m1 ? m1_wdata  : m0_wdata;
    assign g_funct3 = grant_m1 ? m1_funct3 : m0_funct3;

    assign g_ram = (g_addr < RAM_LIMIT);
    assign g_io  = (g_addr >= IO_BASE) && (g_addr <= IO_LAST);
    assign q_ram = (bus_addr < RAM_LIMIT);
    assign q_io  = (bus_addr >= IO_BASE) && (bus_addr <= IO_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            last_owner <= 1'b1;
            owner      <= 1'b0;
            we_q       <= 1'b0;
            bus_addr   <= 32'h0;
            bus_wdata  <= 32'h0;
            bus_funct3 <= 3'h0;
            ram_we     <= 1'b0;
            io_we      <= 1'b0;
            rdata      <= 32'h0;
            m0_done    <= 1'b0;
            m1_done    <= 1'b0;
            m0_err     <= 1'b0;
            m1_err     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (m0_req || m1_req) begin
                        owner      <= grant_m1;
                        last_owner <= grant_m1;
                        we_q       <= g_we;
                        bus_addr   <= g_addr;
                        bus_wdata  <= g_wdata;
                        bus_funct3 <= g_funct3;
                        // Strobes are registered here so they are high exactly during ACCESS.
                        ram_we     <= g_we && g_ram;
                        io_we      <= g_we && g_io;
                        state      <= ACCESS;
                    end
                end
                ACCESS: begin
                    ram_we  <= 1'b0;
                    io_we   <= 1'b0;
                    rdata   <= we_q  ? 32'h0 :
                               q_ram ? ram_rdata :
                               q_io  ? io_rdata : 32'h0;
                    m0_done <= !owner;
                    m1_done <= owner;
                    m0_err  <= !owner && !(q_ram || q_io);
                    m1_err  <= owner && !(q_ram || q_io);
                    state   <= RESP;
                end
                RESP: begin
                    m0_done <= 1'b0;
                    m1_done <= 1'b0;
                    m0_err  <= 1'b0;
                    m1_err  <= 1'b0;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Randomized bench for mem_bus_arbiter with a transaction-level reference model and a scoreboard monitor.
module tb_mem_bus_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        req[2];
    logic        we[2];
    logic [31:0] addr[2];
    logic [31:0] wdata[2];
    logic [2:0]  f3[2];

    logic        m0_done, m1_done, m0_err, m1_err;
    logic [31:0] rdata, bus_addr, bus_wdata;
    logic [2:0]  bus_funct3;
    logic        ram_we, io_we;
    logic [31:0] ram_rdata, io_rdata;
    logic        done_v[2];

    // Slave models: distinct functions of the address so a wrong slave selection is visible.
    assign ram_rdata  = bus_addr ^ 32'hA5A5_0000;
    assign io_rdata   = bus_addr ^ 32'h0000_3C3C;
    assign done_v[0]  = m0_done;
    assign done_v[1]  = m1_done;

    mem_bus_arbiter dut (
        .clk(clk), .reset(reset),
        .m0_req(req[0]), .m1_req(req[1]),
        .m0_we(we[0]), .m1_we(we[1]),
        .m0_addr(addr[0]), .m1_addr(addr[1]),
        .m0_wdata(wdata[0]), .m1_wdata(wdata[1]),
        .m0_funct3(f3[0]), .m1_funct3(f3[1]),
        .m0_done(m0_done), .m1_done(m1_done),
        .m0_err(m0_err), .m1_err(m1_err),
        .rdata(rdata), .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_funct3(bus_funct3),
        .ram_we(ram_we), .io_we(io_we),
        .ram_rdata(ram_rdata), .io_rdata(io_rdata)
    );

    int checks = 0;
    int failures = 0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at t=%0t", name, act, exp, $time);
        end
    endfunction

    function automatic logic is_ram(logic [31:0] a);
        return a < 32'h0000_1000;
    endfunction

    function automatic logic is_io(logic [31:0] a);
        return (a >= 32'h0000_1000) && (a <= 32'h0000_100F);
    endfunction

    function automatic logic [31:0] exp_rdata(logic w, logic [31:0] a);
        if (w)         return 32'h0;
        if (is_ram(a)) return a ^ 32'hA5A5_0000;
        if (is_io(a))  return a ^ 32'h0000_3C3C;
        return 32'h0;
    endfunction

    function automatic logic [31:0] pick_addr();
        case ($urandom_range(0, 7))
            0: return 32'h0000_0FFF;
            1: return 32'h0000_1000;
            2: return 32'h0000_100F;
            3: return 32'h0000_1010;
            4: return 32'h0000_2000;
            5: return $urandom_range(0, 32'hFFF);
            6: return 32'h0000_1000 + $urandom_range(0, 15);
            default: return $urandom;
        endcase
    endfunction

    typedef struct {
        int          id;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [2:0]  f3;
        int          grant;
    } txn_t;

    txn_t q[$];
    int   cyc = 0;
    int   next_free = 0;
    int   last = 1;

    // Reference model: one transaction occupies the bus for three cycles; ties go to the non-last owner.
    always @(posedge clk or negedge reset) begin
        int   w;
        txn_t t;
        if (!reset) begin
            q.delete();
            last = 1;
            next_free = 0;
        end else begin
            cyc++;
            if (cyc >= next_free && (req[0] || req[1])) begin
                if (req[0] && req[1]) w = 1 - last;
                else                  w = req[1] ? 1 : 0;
                t.id = w; t.we = we[w]; t.addr = addr[w]; t.wdata = wdata[w];
                t.f3 = f3[w]; t.grant = cyc;
                q.push_back(t);
                last = w;
                next_free = cyc + 3;
            end
        end
    end

    // Scoreboard monitor: strobes expected in the cycle after grant, done/err the cycle after that.
    always @(negedge clk) begin
        logic acc, rsp, mapped;
        txn_t e;
        if (reset) begin
            e = '{default: 0};
            acc = 1'b0;
            rsp = 1'b0;
            if (q.size() > 0) begin
                e = q[0];
                acc = (cyc == e.grant);
                rsp = (cyc == e.grant + 1);
            end
            mapped = is_ram(e.addr) || is_io(e.addr);
            chk("ram_we",  {31'h0, ram_we},  {31'h0, acc && e.we && is_ram(e.addr)});
            chk("io_we",   {31'h0, io_we},   {31'h0, acc && e.we && is_io(e.addr)});
            chk("m0_done", {31'h0, m0_done}, {31'h0, rsp && e.id == 0});
            chk("m1_done", {31'h0, m1_done}, {31'h0, rsp && e.id == 1});
            chk("m0_err",  {31'h0, m0_err},  {31'h0, rsp && e.id == 0 && !mapped});
            chk("m1_err",  {31'h0, m1_err},  {31'h0, rsp && e.id == 1 && !mapped});
            if (acc) begin
                chk("bus_addr",   bus_addr, e.addr);
                chk("bus_wdata",  bus_wdata, e.wdata);
                chk("bus_funct3", {29'h0, bus_funct3}, {29'h0, e.f3});
            end
            if (rsp) begin
                chk("rdata", rdata, exp_rdata(e.we, e.addr));
                chk("bus_addr_hold", bus_addr, e.addr);
                void'(q.pop_front());
            end
        end
    end

    task automatic wait_done(input int id);
        int t;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!done_v[id] && t < 40);
        checks++;
        if (!done_v[id]) begin
            failures++;
            $display("FAIL done_timeout master=%0d actual=no_done required=done_within_40_cycles", id);
        end
    endtask

    task automatic issue(input int id, input logic w, input logic [31:0] a,
                         input logic [31:0] d, input logic [2:0] f);
        we[id] = w; addr[id] = a; wdata[id] = d; f3[id] = f;
        req[id] = 1'b1;
        wait_done(id);
        req[id] = 1'b0;
    endtask

    task automatic drive(input int id, input int n, input int maxgap);
        int gap;
        for (int k = 0; k < n; k++) begin
            gap = (maxgap == 0) ? 0 : int'($urandom_range(0, maxgap));
            if (gap > 0) begin
                req[id] = 1'b0;
                repeat (gap) @(negedge clk);
            end
            we[id]    = 1'($urandom_range(0, 1));
            addr[id]  = pick_addr();
            wdata[id] = $urandom;
            f3[id]    = 3'($urandom_range(0, 7));
            req[id]   = 1'b1;
            wait_done(id);
        end
        req[id] = 1'b0;
    endtask

    task automatic reset_during_write(input logic [31:0] a);
        @(negedge clk);
        we[0] = 1'b1; addr[0] = a; wdata[0] = 32'hCAFE_F00D; f3[0] = 3'b010;
        req[0] = 1'b1;
        @(negedge clk);
        chk("abort_pre_strobe", {31'h0, ram_we | io_we}, 32'h1);
        #2 reset = 1'b0;
        #1;
        chk("abort_ram_we", {31'h0, ram_we}, 32'h0);
        chk("abort_io_we",  {31'h0, io_we}, 32'h0);
        chk("abort_bus_addr", bus_addr, 32'h0);
        req[0] = 1'b0;
        repeat (2) @(negedge clk);
        chk("abort_no_done", {30'h0, m0_done, m1_done}, 32'h0);
        chk("abort_rdata", rdata, 32'h0);
        reset = 1'b1;
    endtask

    initial begin
        reset = 1'b0;
        for (int i = 0; i < 2; i++) begin
            req[i] = 1'b0; we[i] = 1'b0; addr[i] = 32'h0; wdata[i] = 32'h0; f3[i] = 3'h0;
        end
        repeat (3) @(negedge clk);
        #1;
        chk("rst_done_err", {28'h0, m0_done, m1_done, m0_err, m1_err}, 32'h0);
        chk("rst_strobes",  {30'h0, ram_we, io_we}, 32'h0);
        chk("rst_rdata",    rdata, 32'h0);
        chk("rst_bus_addr", bus_addr, 32'h0);
        chk("rst_bus_wdata", bus_wdata, 32'h0);
        chk("rst_bus_funct3", {29'h0, bus_funct3}, 32'h0);
        @(negedge clk);
        reset = 1'b1;

        // Both masters hold req from reset: strict alternation starting with M0.
        fork
            drive(0, 2, 0);
            drive(1, 2, 0);
        join

        issue(0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 3'b010);
        issue(1, 1'b0, 32'h0000_1004, 32'h0, 3'b010);
        issue(0, 1'b1, 32'h0000_2000, 32'h1234_5678, 3'b000);
        issue(0, 1'b1, 32'h0000_0FFF, 32'h1111_1111, 3'b000);
        issue(1, 1'b1, 32'h0000_1000, 32'h2222_2222, 3'b001);
        issue(0, 1'b1, 32'h0000_100F, 32'h3333_3333, 3'b000);
        issue(1, 1'b1, 32'h0000_1010, 32'h4444_4444, 3'b010);
        issue(0, 1'b0, 32'h0000_0FFF, 32'h0, 3'b100);
        issue(1, 1'b0, 32'hFFFF_FFFC, 32'h0, 3'b010);

        fork
            drive(0, 30, 3);
            drive(1, 30, 3);
        join

        // Aborted M0 write leaves M0 as last owner unless reset restores it; tie must still go to M0.
        reset_during_write(32'h0000_0020);
        fork
            issue(0, 1'b0, 32'h0000_0030, 32'h0, 3'b010);
            issue(1, 1'b0, 32'h0000_1008, 32'h0, 3'b010);
        join
        reset_during_write(32'h0000_1004);
        issue(1, 1'b1, 32'h0000_0040, 32'h5555_AAAA, 3'b010);

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
